button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 152 +++++++++++++++
 tb/tb_button_debouncer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: 2-flop synchronizer, per-channel debounce FSM,
// registered level/press/release. Define BTN_REPEAT_EN for auto-repeat on REPEAT_MASK channels.
module button_debouncer #(
   parameter int unsigned        NUM_BTN         = 2,
   parameter int unsigned        DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned        REPEAT_DELAY    = 50_000_000,
   parameter int unsigned        REPEAT_PERIOD   = 20_000_000,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(2'b01)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release
);

`ifdef BTN_REPEAT_EN
   localparam bit REPEAT_ON = 1'b1;
`else
   localparam bit REPEAT_ON = 1'b0;
`endif

   localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int unsigned MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
   localparam int unsigned MAX_CNT = REPEAT_ON ? MAX_ALL : DEBOUNCE_CYCLES;
   localparam int unsigned CW      = $clog2(MAX_CNT + 1);

   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] PRESS_CNT = 2'd1;
   localparam logic [1:0] HELD      = 2'd2;
   localparam logic [1:0] REL_CNT   = 2'd3;

   logic [NUM_BTN-1:0] sync1;
   logic [NUM_BTN-1:0] sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      logic [1:0]    state;
      logic [CW-1:0] cnt;
      logic          level_q;
      logic          press_q;
      logic          rel_q;
      logic          rpt_fire;
      logic          s;

      assign s = sync2[i];

      // Repeat timer only exists for enabled channels in the repeat build.
      if (REPEAT_ON && REPEAT_MASK[i]) begin : g_rpt
         localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
         localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

         logic [CW-1:0] rpt_cnt;
         logic          first;
         logic [CW-1:0] rpt_last;

         always_comb begin
            rpt_last = first ? RD_LAST : RP_LAST;
         end

         assign rpt_fire = (state == HELD) && s && (rpt_cnt == rpt_last);

         always_ff @(posedge clk) begin
            if (rst || (state != HELD) || !s) begin
               rpt_cnt <= '0;
               first   <= 1'b1;
            end else if (rpt_fire) begin
               rpt_cnt <= '0;
               first   <= 1'b0;
            end else begin
               rpt_cnt <= rpt_cnt + 1'b1;
            end
         end
      end else begin : g_no_rpt
         assign rpt_fire = 1'b0;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            press_q <= rpt_fire;
            rel_q   <= 1'b0;
            case (state)
               IDLE: begin
                  if (s) begin
                     state <= PRESS_CNT;
                     cnt   <= CW'(1);
                  end
               end
               PRESS_CNT: begin
                  if (!s) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (cnt == DEB_LAST) begin
                     state   <= HELD;
                     cnt     <= '0;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               HELD: begin
                  if (!s) begin
                     state <= REL_CNT;
                     cnt   <= CW'(1);
                  end
               end
               REL_CNT: begin
                  if (s) begin
                     state <= HELD;
                     cnt   <= '0;
                  end else if (cnt == DEB_LAST) begin
                     state   <= IDLE;
                     cnt     <= '0;
                     level_q <= 1'b0;
                     rel_q   <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = rel_q;
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_button_debouncer;

   localparam int unsigned DB = 4;
   localparam int unsigned RD = 10;
   localparam int unsigned RP = 5;

`ifdef BTN_REPEAT_EN
   localparam bit RPT_ON = 1'b1;
`else
   localparam bit RPT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] btn_in;
   logic [1:0] btn_level;
   logic [1:0] btn_press;
   logic [1:0] btn_release;

   int n_tests = 0;
   int n_fail  = 0;

   button_debouncer #(
      .NUM_BTN        (2),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP),
      .REPEAT_MASK    (2'b01)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release)
   );

   initial forever #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int k, input logic [1:0] obs, input logic [1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input int k,
                            input logic [1:0] ep, input logic [1:0] er, input logic [1:0] el);
      check({tag, "_press"},   k, btn_press,   ep);
      check({tag, "_release"}, k, btn_release, er);
      check({tag, "_level"},   k, btn_level,   el);
   endtask

   // Repeat pulse on channel 0: accepted at acc, input falls (sampled low) at fall.
   function automatic logic rpt_hit(input int k, input int acc, input int fall);
      return RPT_ON && (k > acc) && (k <= fall + 1) && ((k - acc) >= int'(RD))
             && (((k - acc - int'(RD)) % int'(RP)) == 0);
   endfunction

   initial begin
      logic [1:0] ep, er, el;

      rst    = 1'b1;
      btn_in = 2'b00;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_all("reset", k, 2'b00, 2'b00, 2'b00);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_all("idle", k, 2'b00, 2'b00, 2'b00);
      end

      // Clean press on ch0, release at cycle 20
      for (int k = 0; k < 30; k++) begin
         btn_in = {1'b0, (k < 20)};
         tick();
         ep = {1'b0, (k == 6) || rpt_hit(k, 6, 20)};
         er = {1'b0, (k == 26)};
         el = {1'b0, (k >= 6) && (k < 26)};
         check_all("clean", k, ep, er, el);
      end

      // Bounce on press, 2-cycle glitch while held, then real release at 30
      for (int k = 0; k < 41; k++) begin
         btn_in = {1'b0, !((k == 3) || (k == 15) || (k == 16) || (k >= 30))};
         tick();
         ep = {1'b0, (k == 10) || (RPT_ON && (k == 29))};
         er = {1'b0, (k == 36)};
         el = {1'b0, (k >= 10) && (k < 36)};
         check_all("bounce", k, ep, er, el);
      end

      // Simultaneous press and release on both channels
      for (int k = 0; k < 17; k++) begin
         btn_in = (k < 9) ? 2'b11 : 2'b00;
         tick();
         ep = (k == 6) ? 2'b11 : 2'b00;
         er = (k == 15) ? 2'b11 : 2'b00;
         el = ((k >= 6) && (k < 15)) ? 2'b11 : 2'b00;
         check_all("simul", k, ep, er, el);
      end

      // Reset mid-count while held: re-accepted 6 cycles after rst falls
      for (int k = 0; k < 23; k++) begin
         btn_in = (k < 15) ? 2'b11 : 2'b00;
         rst    = (k == 3) || (k == 4);
         tick();
         ep = (k == 11) ? 2'b11 : 2'b00;
         er = (k == 21) ? 2'b11 : 2'b00;
         el = ((k >= 11) && (k < 21)) ? 2'b11 : 2'b00;
         check_all("rst_cnt", k, ep, er, el);
      end
      rst = 1'b0;

      // Long hold: auto-repeat on ch0 only when enabled
      for (int k = 0; k < 48; k++) begin
         btn_in = (k < 40) ? 2'b11 : 2'b00;
         tick();
         ep = {(k == 6), (k == 6) || rpt_hit(k, 6, 40)};
         er = (k == 46) ? 2'b11 : 2'b00;
         el = ((k >= 6) && (k < 46)) ? 2'b11 : 2'b00;
         check_all("hold", k, ep, er, el);
      end

      // Reset while HELD: level drops, no release, press re-accepted
      for (int k = 0; k < 17; k++) begin
         btn_in = 2'b11;
         rst    = (k == 8);
         tick();
         ep = ((k == 6) || (k == 15)) ? 2'b11 : 2'b00;
         er = 2'b00;
         el = (((k >= 6) && (k < 8)) || (k >= 15)) ? 2'b11 : 2'b00;
         check_all("rst_held", k, ep, er, el);
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
